// File: rtl/gpu_regs_pkg.sv
// Shared definitions for the GPU register file: sizes, register indices,
// CTRL/STATUS bit positions, launcher FSM encoding and small helpers.
package gpu_regs_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_REGS   = 11;
  localparam int unsigned NUM_PARAMS = NUM_REGS - 2;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

  localparam int unsigned CTRL_IDX   = 0;
  localparam int unsigned STATUS_IDX = 1;
  localparam int unsigned PARAM_BASE = 2;

  localparam int unsigned CTRL_GO_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam int unsigned STATUS_BUSY_BIT    = 0;
  localparam int unsigned STATUS_DONE_BIT    = 1;
  localparam int unsigned STATUS_OVERRUN_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } cmd_state_e;

  // PARAM0 sits in the least significant word.
  typedef logic [NUM_PARAMS-1:0][DATA_WIDTH-1:0] param_bank_t;

  // True when exactly one select bit is set.
  function automatic logic is_onehot(input logic [NUM_REGS-1:0] v);
    return (v != '0) && ((v & (v - NUM_REGS'(1))) == '0);
  endfunction

  // Merge new write data into an old register value per byte lane.
  function automatic logic [DATA_WIDTH-1:0] be_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpu_cmd_launcher.sv
// Command launcher: shadows the PARAM bank on GO, offers it to the raster
// engine over valid/ready, waits for completion and keeps busy/done/overrun
// flags plus the level interrupt.
// Ports:
//   i_go / i_done_clr / i_overrun_clr : decoded register-write events
//   i_irq_en                          : CTRL.IRQ_EN
//   i_params                          : live PARAM0..8 registers
//   i_cmd_ready / i_cmd_done          : raster engine handshake / completion
//   o_cmd_valid / o_cmd_params        : command offer and shadowed params
//   o_busy / o_done / o_overrun / o_irq : status flags and interrupt
module gpu_cmd_launcher
  import gpu_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_go,
  input  logic        i_done_clr,
  input  logic        i_overrun_clr,
  input  logic        i_irq_en,
  input  param_bank_t i_params,
  input  logic        i_cmd_ready,
  input  logic        i_cmd_done,
  output logic        o_cmd_valid,
  output param_bank_t o_cmd_params,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overrun,
  output logic        o_irq
);

  cmd_state_e  r_state;
  cmd_state_e  w_state_nxt;
  logic        w_capture;
  logic        w_done_set;
  logic        w_overrun_set;
  param_bank_t r_shadow;
  logic        r_cmd_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_overrun;
  logic        r_irq;

  // Next-state and event decode; cmd_done only counts in WAIT_DONE.
  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_done_set    = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_go) begin
          w_state_nxt = ST_ISSUE;
          w_capture   = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_overrun_set = i_go;
        if (i_cmd_ready) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        w_overrun_set = i_go;
        if (i_cmd_done) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, registered outputs and sticky flags (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shadow    <= '0;
      r_cmd_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= (w_state_nxt == ST_ISSUE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_capture) r_shadow <= i_params;
      r_done      <= w_done_set    | (r_done    & ~i_done_clr);
      r_overrun   <= w_overrun_set | (r_overrun & ~i_overrun_clr);
      r_irq       <= i_irq_en & (r_done | r_overrun);
    end
  end

  assign o_cmd_valid  = r_cmd_valid;
  assign o_cmd_params = r_shadow;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_overrun    = r_overrun;
  assign o_irq        = r_irq;

endmodule

// File: rtl/gpu_register_file.sv
// GPU register file behind the QSYS address decoder: CTRL, STATUS and
// PARAM0..8 with byte-enabled writes, latency-1 registered reads, and a
// command launcher driving the raster engine.
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   select/write/read/writedata/byteenable : Avalon-MM slave side
//   readdata/readdatavalid            : registered read response
//   cmd_valid/cmd_ready/cmd_params    : command handshake to raster engine
//   cmd_done                          : completion pulse
//   busy, irq                         : command in flight, HPS interrupt
module gpu_register_file
  import gpu_regs_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REGS-1:0]              select,
  input  logic                             write,
  input  logic                             read,
  input  logic [DATA_WIDTH-1:0]            writedata,
  input  logic [BE_WIDTH-1:0]              byteenable,
  output logic [DATA_WIDTH-1:0]            readdata,
  output logic                             readdatavalid,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [NUM_PARAMS*DATA_WIDTH-1:0] cmd_params,
  input  logic                             cmd_done,
  output logic                             busy,
  output logic                             irq
);

  param_bank_t           r_params;
  logic                  r_irq_en;
  logic [DATA_WIDTH-1:0] r_readdata;
  logic                  r_readdatavalid;

  logic                  w_sel_ok;
  logic                  w_wr_ctrl;
  logic                  w_wr_status;
  logic                  w_go;
  logic                  w_done_clr;
  logic                  w_overrun_clr;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_overrun;
  param_bank_t           w_cmd_params;
  logic [DATA_WIDTH-1:0] w_ctrl_rd;
  logic [DATA_WIDTH-1:0] w_status_rd;
  logic [DATA_WIDTH-1:0] w_rd_mux;

  // Multi-hot selects are treated as no register for both reads and writes.
  assign w_sel_ok      = is_onehot(select);
  assign w_wr_ctrl     = write & w_sel_ok & select[CTRL_IDX];
  assign w_wr_status   = write & w_sel_ok & select[STATUS_IDX];
  assign w_go          = w_wr_ctrl   & byteenable[0] & writedata[CTRL_GO_BIT];
  assign w_done_clr    = w_wr_status & byteenable[0] & writedata[STATUS_DONE_BIT];
  assign w_overrun_clr = w_wr_status & byteenable[0] & writedata[STATUS_OVERRUN_BIT];

  // Readback views; GO always reads 0.
  always_comb begin
    w_ctrl_rd                     = '0;
    w_ctrl_rd[CTRL_IRQ_EN_BIT]    = r_irq_en;
    w_status_rd                   = '0;
    w_status_rd[STATUS_BUSY_BIT]  = w_busy;
    w_status_rd[STATUS_DONE_BIT]  = w_done;
    w_status_rd[STATUS_OVERRUN_BIT] = w_overrun;
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    w_rd_mux = '0;
    if (w_sel_ok) begin
      if (select[CTRL_IDX])   w_rd_mux = w_ctrl_rd;
      if (select[STATUS_IDX]) w_rd_mux = w_status_rd;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        if (select[PARAM_BASE + i]) w_rd_mux = r_params[i];
      end
    end
  end

  // Register array and read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_params        <= '0;
      r_irq_en        <= 1'b0;
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= read;
      r_readdata      <= read ? w_rd_mux : '0;
      if (w_wr_ctrl && byteenable[0]) r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        if (write && w_sel_ok && select[PARAM_BASE + i]) begin
          r_params[i] <= be_merge(r_params[i], writedata, byteenable);
        end
      end
    end
  end

  gpu_cmd_launcher u_launcher (
    .clk           (clk),
    .rst_n         (reset_n),
    .i_go          (w_go),
    .i_done_clr    (w_done_clr),
    .i_overrun_clr (w_overrun_clr),
    .i_irq_en      (r_irq_en),
    .i_params      (r_params),
    .i_cmd_ready   (cmd_ready),
    .i_cmd_done    (cmd_done),
    .o_cmd_valid   (cmd_valid),
    .o_cmd_params  (w_cmd_params),
    .o_busy        (w_busy),
    .o_done        (w_done),
    .o_overrun     (w_overrun),
    .o_irq         (irq)
  );

  assign readdata      = r_readdata;
  assign readdatavalid = r_readdatavalid;
  assign cmd_params    = w_cmd_params;
  assign busy          = w_busy;

endmodule

// File: tb/tb_gpu_register_file.sv
// Directed bench for gpu_register_file with hand-computed expectations.
module tb_gpu_register_file;

  logic          clk;
  logic          reset_n;
  logic [10:0]   select;
  logic          write;
  logic          read;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic [31:0]   readdata;
  logic          readdatavalid;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [287:0]  cmd_params;
  logic          cmd_done;
  logic          busy;
  logic          irq;

  int n_checks;
  int n_fail;

  localparam logic [10:0] SEL_CTRL   = 11'h001;
  localparam logic [10:0] SEL_STATUS = 11'h002;

  gpu_register_file dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .select        (select),
    .write         (write),
    .read          (read),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_params    (cmd_params),
    .cmd_done      (cmd_done),
    .busy          (busy),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The decoder guarantees one-hot selects on writes.
  always @(posedge clk) begin
    if (write) assert ($onehot0(select)) else $error("write with multi-hot select %h", select);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [10:0] sel, input logic [31:0] data, input logic [3:0] be);
    select = sel; writedata = data; byteenable = be; write = 1'b1;
    tick();
    write = 1'b0; select = '0;
  endtask

  task automatic bus_read(input logic [10:0] sel, output logic [31:0] data);
    select = sel; read = 1'b1;
    tick();
    data = readdata;
    chk("rdv", 32'(readdatavalid), 32'd1);
    read = 1'b0; select = '0;
  endtask

  function automatic logic [31:0] pfield(input logic [287:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  logic [31:0] rd;
  int          vcnt;

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; select = '0; write = 1'b0; read = 1'b0;
    writedata = '0; byteenable = '0; cmd_ready = 1'b0; cmd_done = 1'b0;

    // Reset state.
    repeat (2) tick();
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdv", 32'(readdatavalid), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    tick();

    // Every select reads 0 with latency exactly 1; zero select also reads 0.
    for (int i = 0; i <= 11; i++) begin
      select = (i == 11) ? 11'h000 : 11'(1 << i);
      read = 1'b1;
      chk("pre_rdv", 32'(readdatavalid), 32'd0);
      tick();
      chk("rd_rdv", 32'(readdatavalid), 32'd1);
      chk("rd_zero", readdata, 32'd0);
      read = 1'b0; select = '0;
      tick();
      chk("post_rdv", 32'(readdatavalid), 32'd0);
    end

    // Byte-enabled write of PARAM3.
    bus_write(11'h020, 32'hDEADBEEF, 4'b0101);
    bus_read(11'h020, rd);
    chk("param3_be", rd, 32'h00AD00EF);

    // Launch with cmd_ready held low for 5 cycles.
    for (int i = 0; i < 9; i++) bus_write(11'(1 << (2 + i)), 32'(i + 1), 4'hF);
    bus_write(SEL_CTRL, 32'h3, 4'hF);
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (cmd_valid) vcnt++;
      chk("issue_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 9; i++) chk("issue_params", pfield(cmd_params, i), 32'(i + 1));
      if (k == 5) cmd_ready = 1'b1;
      tick();
    end
    cmd_ready = 1'b0;
    chk("valid_cycles", 32'(vcnt), 32'd6);
    chk("valid_drop", 32'(cmd_valid), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    bus_read(SEL_STATUS, rd);
    chk("status_busy", rd, 32'h1);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    chk("done_busy", 32'(busy), 32'd0);
    chk("irq_not_yet", 32'(irq), 32'd0);
    tick();
    chk("irq_after_done", 32'(irq), 32'd1);
    bus_read(SEL_STATUS, rd);
    chk("status_done", rd, 32'h2);
    bus_read(SEL_CTRL, rd);
    chk("ctrl_read", rd, 32'h2);

    // Clear DONE, then launch again and exercise WAIT_DONE writes.
    bus_write(SEL_STATUS, 32'h2, 4'hF);
    tick();
    chk("irq_cleared", 32'(irq), 32'd0);
    cmd_ready = 1'b1;
    bus_write(SEL_CTRL, 32'h3, 4'hF);
    chk("go2_valid", 32'(cmd_valid), 32'd1);
    tick();
    cmd_ready = 1'b0;
    chk("go2_handshake", 32'(cmd_valid), 32'd0);
    bus_write(11'h004, 32'h55, 4'hF);
    bus_write(SEL_CTRL, 32'h3, 4'hF);
    chk("wd_param0_shadow", pfield(cmd_params, 0), 32'd1);
    bus_read(11'h004, rd);
    chk("wd_param0_reg", rd, 32'h55);
    bus_read(SEL_STATUS, rd);
    chk("status_overrun", rd, 32'h5);
    vcnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (cmd_valid) vcnt++;
      tick();
    end
    chk("no_second_valid", 32'(vcnt), 32'd0);

    // W1C of DONE|OVERRUN coinciding with cmd_done: DONE set wins.
    select = SEL_STATUS; writedata = 32'h6; byteenable = 4'hF; write = 1'b1; cmd_done = 1'b1;
    tick();
    write = 1'b0; select = '0; cmd_done = 1'b0;
    bus_read(SEL_STATUS, rd);
    chk("set_wins", rd, 32'h2);
    chk("irq_held", 32'(irq), 32'd1);
    bus_write(SEL_STATUS, 32'h2, 4'hF);
    tick();
    chk("irq_drop", 32'(irq), 32'd0);
    bus_read(SEL_STATUS, rd);
    chk("status_clear", rd, 32'h0);

    // Back-to-back: GO in the cycle right after returning to IDLE.
    cmd_ready = 1'b1;
    bus_write(SEL_CTRL, 32'h3, 4'hF);
    tick();
    cmd_ready = 1'b0;
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    chk("b2b_idle", 32'(busy), 32'd0);
    bus_write(SEL_CTRL, 32'h3, 4'hF);
    chk("b2b_valid", 32'(cmd_valid), 32'd1);
    chk("b2b_busy", 32'(busy), 32'd1);

    // GO in ISSUE raises OVERRUN and irq; then reset mid-command.
    bus_write(SEL_CTRL, 32'h3, 4'hF);
    tick();
    chk("issue_irq", 32'(irq), 32'd1);
    bus_read(SEL_STATUS, rd);
    chk("issue_overrun", rd, 32'h7);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(cmd_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(cmd_valid), 32'd0);
    bus_write(SEL_CTRL, 32'h1, 4'hF);
    chk("post_rst_go", 32'(cmd_valid), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_param0", pfield(cmd_params, 0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_register_file.md
Name: gpu_register_file

Overview:
- Register file directly downstream of the QSYS address decoder: consumes its 11-bit one-hot register select together with the Avalon-MM write/read strobes.
- Holds the GPU command registers and launches one draw command per GO write to the raster engine over a valid/ready handshake.
- Tracks busy/done and raises an interrupt to the HPS.
- Parameter registers are shadowed at launch, so software can program the next command while the current one runs.

Parameters:
- DATA_WIDTH, 32, width of every register and of the Avalon data bus.
- NUM_REGS, 11, number of registers; equals the select width. Index 0 is CTRL, 1 is STATUS, 2..10 are PARAM0..PARAM8.
- NUM_PARAMS, 9, number of PARAM registers (NUM_REGS-2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- select  in  NUM_REGS  one-hot register select from the address decoder; all-zero means no register.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- writedata  in  DATA_WIDTH  write data.
- byteenable  in  DATA_WIDTH/8  byte lanes for writes.
- readdata  out  DATA_WIDTH  registered read data.
- readdatavalid  out  1  read response strobe.
- cmd_valid  out  1  command offered to the raster engine.
- cmd_ready  in  1  raster engine accepts the command.
- cmd_params  out  NUM_PARAMS*DATA_WIDTH  shadowed PARAM0..8; PARAM0 occupies the LSBs.
- cmd_done  in  1  one-cycle pulse: command finished.
- busy  out  1  a command is in flight.
- irq  out  1  level interrupt.

Behaviour:
- Reset, asynchronous on reset_n low: all registers, shadows, readdata, readdatavalid, cmd_valid, busy and irq go to 0; FSM goes to IDLE. Reset mid-command drops cmd_valid immediately and discards the command.
- Write: on write=1, the register at the single set select bit updates per byteenable in the next cycle.
  - select all-zero: no effect.
  - select with more than one bit set: write ignored (decoder guarantees one-hot; the bench asserts on this).
- CTRL fields:
  - bit0 GO: write-1 triggers; self-clears and always reads 0.
  - bit1 IRQ_EN: read/write.
  - Other bits read 0.
- STATUS fields:
  - bit0 BUSY: read-only.
  - bit1 DONE: sticky, write-1-to-clear.
  - bit2 OVERRUN: sticky, write-1-to-clear.
  - Other bits read 0; writes to BUSY are ignored.
- PARAM0..8: plain read/write at all times. Writes while busy do not affect cmd_params.
- Read: read=1 gives readdatavalid=1 and readdata=selected register one cycle later (latency 1). A zero or invalid select returns 0. Simultaneous read and write to the same register returns the old value.
- FSM states:
  - IDLE: a GO write copies PARAM0..8 into the shadow (new writedata included if the same cycle writes a PARAM; it cannot, since select is one-hot), then moves to ISSUE and sets busy=1.
  - ISSUE: cmd_valid=1 and cmd_params stable until cmd_ready=1. On cmd_valid&cmd_ready, go to WAIT_DONE and drop cmd_valid in the next cycle.
  - WAIT_DONE: on cmd_done, go to IDLE, set busy=0 and DONE=1.
- cmd_done outside WAIT_DONE is ignored, including in ISSUE when it coincides with cmd_ready.
- GO while busy (ISSUE or WAIT_DONE): ignored and sets OVERRUN=1.
- A STATUS W1C on the same cycle that DONE or OVERRUN is set: set wins.
- irq = IRQ_EN & (DONE | OVERRUN), registered, so it asserts 1 cycle after the flag sets.
- Back-to-back: a GO written in the cycle after the FSM returns to IDLE is accepted.

Decomposition:
- Shared package gpu_regs_pkg:
  - register indices (CTRL_IDX=0, STATUS_IDX=1, PARAM_BASE=2);
  - CTRL and STATUS bit positions;
  - FSM state encoding;
  - NUM_REGS.
- One natural sub-module: gpu_cmd_launcher, holding the FSM, shadow registers and the busy/done/overrun logic. The top level keeps the register array and the read mux.

Test Plan:
- Reset, then a read of every select (1<<i): readdata=0 for all, readdatavalid exactly one cycle after read.
- Write PARAM3 (select=11'h020)=32'hDEADBEEF with byteenable=4'b0101, then read it: returns 32'h00AD00EF.
- PARAM0..8 = i+1, write CTRL=32'h3, hold cmd_ready=0 for 5 cycles then 1: cmd_valid high for 6 cycles with cmd_params stable; busy=1; then pulse cmd_done: busy=0, STATUS reads 32'h2, irq=1 one cycle after DONE sets.
- While in WAIT_DONE: write PARAM0=32'h55 and write GO. Required: cmd_params PARAM0 field unchanged, OVERRUN set (STATUS=32'h5), no second cmd_valid.
- STATUS write 32'h6 in the same cycle as cmd_done in WAIT_DONE: DONE remains 1, OVERRUN cleared. A following W1C of 32'h2 clears DONE and drops irq.
- Assert reset_n=0 in ISSUE: cmd_valid, busy and irq go to 0 at once; after release the FSM is in IDLE and a new GO is accepted.
